// File: rtl/wb_pkg.sv
// Shared encodings and state type for the writeback stage.
package wb_pkg;

    localparam logic [1:0] WB_SEL_ALU = 2'b00;
    localparam logic [1:0] WB_SEL_MEM = 2'b01;
    localparam logic [1:0] WB_SEL_PC4 = 2'b10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE     = 2'b00,
        S_WAIT_MEM = 2'b01,
        S_COMMIT   = 2'b10
    } wb_state_t;

endpackage

// File: rtl/wb_if.sv
// Execute-to-writeback handshake bundle.
interface wb_if #(
    parameter int XLEN = 32
);
    logic            ex_valid;
    logic            ex_ready;
    logic [4:0]      ex_rd;
    logic [1:0]      ex_wb_sel;
    logic [XLEN-1:0] ex_alu_result;
    logic [XLEN-1:0] ex_pc4;
    logic [2:0]      ex_funct3;

    modport master (
        output ex_valid, ex_rd, ex_wb_sel,
        output ex_alu_result, ex_pc4, ex_funct3,
        input  ex_ready
    );

    modport slave (
        input  ex_valid, ex_rd, ex_wb_sel,
        input  ex_alu_result, ex_pc4, ex_funct3,
        output ex_ready
    );

endinterface

// File: rtl/load_align.sv
// Load data alignment: picks byte/halfword from the raw word and extends it.
module load_align
    import wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      i_funct3,
    input  logic [1:0]      i_offset,
    input  logic [XLEN-1:0] i_raw,
    output logic [XLEN-1:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_raw[7:0];
        case (i_offset)
            2'b00: w_byte = i_raw[7:0];
            2'b01: w_byte = i_raw[15:8];
            2'b10: w_byte = i_raw[23:16];
            2'b11: w_byte = i_raw[31:24];
        endcase
        // offset[0] is irrelevant for halfwords: misalignment traps upstream
        w_half = i_offset[1] ? i_raw[31:16] : i_raw[15:0];
    end

    always_comb begin
        o_data = i_raw;
        case (i_funct3)
            F3_LB:   o_data = {{(XLEN-8){w_byte[7]}}, w_byte};
            F3_LBU:  o_data = {{(XLEN-8){1'b0}}, w_byte};
            F3_LH:   o_data = {{(XLEN-16){w_half[15]}}, w_half};
            F3_LHU:  o_data = {{(XLEN-16){1'b0}}, w_half};
            F3_LW:   o_data = i_raw;
            default: o_data = i_raw;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: one register-file write per retiring instruction.
// Optional retired-instruction counter enabled by WB_INSTRET_EN.
module wb_stage
    import wb_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    wb_if.slave              ex,
    input  logic             dmem_resp_valid,
    input  logic [XLEN-1:0]  dmem_resp_data,
    output logic             rf_we,
    output logic [4:0]       rf_wb_addr,
    output logic [XLEN-1:0]  rf_wb_data,
    output logic             fwd_valid,
    output logic [4:0]       fwd_rd,
    output logic [XLEN-1:0]  fwd_data,
    output logic             wb_busy,
    output logic [CNT_W-1:0] instret
);

    wb_state_t       r_state;
    wb_state_t       w_next;
    logic [4:0]      r_rd;
    logic [1:0]      r_sel;
    logic [XLEN-1:0] r_alu;
    logic [XLEN-1:0] r_pc4;
    logic [2:0]      r_f3;
    logic [XLEN-1:0] r_ld;
    logic [XLEN-1:0] w_ld;
    logic [XLEN-1:0] w_data;
    logic            w_accept;
    logic            w_resp;

    assign ex.ex_ready = (r_state != S_WAIT_MEM);
    assign w_accept    = ex.ex_valid && ex.ex_ready;
    assign w_resp      = (r_state == S_WAIT_MEM) && dmem_resp_valid;

    load_align #(.XLEN(XLEN)) u_align (
        .i_funct3 (r_f3),
        .i_offset (r_alu[1:0]),
        .i_raw    (dmem_resp_data),
        .o_data   (w_ld)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_COMMIT: begin
                if (w_accept) begin
                    w_next = (ex.ex_wb_sel == WB_SEL_MEM) ? S_WAIT_MEM : S_COMMIT;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_WAIT_MEM: begin
                if (dmem_resp_valid) begin
                    w_next = S_COMMIT;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd  <= '0;
            r_sel <= WB_SEL_ALU;
            r_alu <= '0;
            r_pc4 <= '0;
            r_f3  <= '0;
            r_ld  <= '0;
        end else begin
            if (w_accept) begin
                r_rd  <= ex.ex_rd;
                r_sel <= ex.ex_wb_sel;
                r_alu <= ex.ex_alu_result;
                r_pc4 <= ex.ex_pc4;
                r_f3  <= ex.ex_funct3;
            end
            if (w_resp) begin
                r_ld <= w_ld;
            end
        end
    end

    // Reserved select 11 behaves as ALU
    always_comb begin
        w_data = r_alu;
        case (r_sel)
            WB_SEL_ALU: w_data = r_alu;
            WB_SEL_MEM: w_data = r_ld;
            WB_SEL_PC4: w_data = r_pc4;
            2'b11:      w_data = r_alu;
        endcase
    end

    assign rf_we      = (r_state == S_COMMIT) && (r_rd != 5'd0);
    assign rf_wb_addr = r_rd;
    assign rf_wb_data = w_data;
    assign fwd_valid  = rf_we;
    assign fwd_rd     = rf_wb_addr;
    assign fwd_data   = rf_wb_data;
    assign wb_busy    = (r_state == S_WAIT_MEM);

`ifdef WB_INSTRET_EN
    logic [CNT_W-1:0] r_instret;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_instret <= '0;
        end else if (r_state == S_COMMIT) begin
            r_instret <= r_instret + 1'b1;
        end
    end

    assign instret = r_instret;
`else
    assign instret = '0;
`endif

endmodule
